intu_issue_arbiter: RTL

Round-robin issue arbiter sharing one INTU cluster between all resident warps. It picks one requesting warp per cycle, returns a same-cycle grant to that warp, and drives registered warp/valid signals into the INTU cluster's `fuWarp_i`/`fuPacketValid_i`. Multi-cycle (long) integer ops such as MUL/DIV block new grants for a fixed occupancy window. A writeback stall from downstream freezes issue.

---
 rtl/intu_issue_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/intu_issue_arbiter.sv
// Round-robin issue arbiter feeding one shared INTU cluster.
// Optional perf counters: define INTU_ARB_PERF_EN.
module intu_issue_arbiter #(
  parameter int NUM_WARP     = 8,
  parameter int NUM_WARP_LOG = 3,
  parameter int LONG_LAT     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_WARP-1:0]     req_i,
  input  logic [NUM_WARP-1:0]     long_i,
  input  logic                    wbStall_i,
  output logic [NUM_WARP-1:0]     grant_o,
  output logic [NUM_WARP_LOG-1:0] fuWarp_o,
  output logic                    fuPacketValid_o,
  output logic                    busy_o
`ifdef INTU_ARB_PERF_EN
  ,
  output logic [31:0]             perfGrant_o,
  output logic [31:0]             perfBlock_o
`endif
);

  localparam int PW = NUM_WARP_LOG + 1;
  localparam logic [PW-1:0] NW = PW'(NUM_WARP);
  localparam logic [NUM_WARP_LOG-1:0] LAST =
    NUM_WARP_LOG'(NUM_WARP - 1);
  localparam logic [3:0] LONG_INIT = 4'(LONG_LAT - 1);

  logic [NUM_WARP_LOG-1:0] rrPtr;
  logic [NUM_WARP_LOG-1:0] pickIdx;
  logic [NUM_WARP_LOG-1:0] nextPtr;
  logic [PW-1:0]           cand;
  logic                    pickHit;
  logic                    eligible;
  logic                    grantVld;
  logic                    longPick;
  logic [3:0]              busyCnt;
  logic [3:0]              busyNext;

  // Find first request at or after rrPtr, wrapping past the top.
  always_comb begin
    pickHit = 1'b0;
    pickIdx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_WARP; i++) begin
      cand = {1'b0, rrPtr} + PW'(i);
      if (cand >= NW) cand = cand - NW;
      if (!pickHit && req_i[cand[NUM_WARP_LOG-1:0]]) begin
        pickHit = 1'b1;
        pickIdx = cand[NUM_WARP_LOG-1:0];
      end
    end
  end

  // Reset is folded in so no grant leaks out while held.
  assign eligible = reset && (busyCnt == 4'd0) && !wbStall_i;
  assign grantVld = eligible && pickHit;
  assign longPick = long_i[pickIdx];
  assign nextPtr  = (pickIdx == LAST) ? '0
                  : pickIdx + NUM_WARP_LOG'(1);

  // One-hot same-cycle grant.
  always_comb begin
    grant_o = '0;
    if (grantVld) grant_o[pickIdx] = 1'b1;
  end

  // Occupancy counter: load on long grant, else count down to 0.
  always_comb begin
    busyNext = busyCnt;
    if (grantVld && longPick) busyNext = LONG_INIT;
    else if (busyCnt != 4'd0) busyNext = busyCnt - 4'd1;
  end

  // Pointer, issue packet and occupancy state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rrPtr           <= '0;
      fuWarp_o        <= '0;
      fuPacketValid_o <= 1'b0;
      busyCnt         <= 4'd0;
      busy_o          <= 1'b0;
    end else begin
      fuPacketValid_o <= grantVld;
      busyCnt         <= busyNext;
      busy_o          <= (busyNext != 4'd0);
      if (grantVld) begin
        rrPtr    <= nextPtr;
        fuWarp_o <= pickIdx;
      end
    end
  end

`ifdef INTU_ARB_PERF_EN
  // Saturating grant and blocked-request counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perfGrant_o <= '0;
      perfBlock_o <= '0;
    end else begin
      if (grantVld && (perfGrant_o != '1))
        perfGrant_o <= perfGrant_o + 32'd1;
      if ((|req_i) && !grantVld && (perfBlock_o != '1))
        perfBlock_o <= perfBlock_o + 32'd1;
    end
  end
`endif

endmodule
